// File: rtl/heap_sort_sequencer_pkg.sv
// Shared types and defaults for the heap-sort sequencer and its order checker.
package heap_sort_sequencer_pkg;

    localparam int N_DEFAULT = 10;
    localparam int W_DEFAULT = 16;
    localparam int ERR_MAX   = 255;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/sort_order_checker.sv
// Watches the popped key stream and counts keys smaller than their predecessor,
// saturating at ERR_MAX. The count survives across runs until reset.
module sort_order_checker
    import heap_sort_sequencer_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         pop,
    input  logic         first,
    input  logic         clear,
    input  logic [W-1:0] key,
    output logic [7:0]   err_cnt
);

    logic [W-1:0] prev_key;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_key <= '0;
            err_cnt  <= '0;
        end else if (clear) begin
            prev_key <= '0;
        end else if (pop) begin
            prev_key <= key;
            // The first key of a run has no predecessor, so it is never an error.
            if (!first && (key < prev_key) && (err_cnt != 8'(ERR_MAX)))
                err_cnt <= err_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/heap_sort_sequencer.sv
// Sequences one heap-sort run: latch N keys, push them into the priority queue,
// then pop them through a registered valid/ready stream while checking order.
module heap_sort_sequencer
    import heap_sort_sequencer_pkg::*;
#(
    parameter int N = N_DEFAULT,
    parameter int W = W_DEFAULT
) (
    input  logic           system1000,
    input  logic           system1000_rst,
    input  logic [N*W:0]   stim_i,
    output logic           stim_ready_o,
    output logic           pq_push_o,
    output logic [W-1:0]   pq_din_o,
    input  logic           pq_full_i,
    output logic           pq_pop_o,
    input  logic [W-1:0]   pq_dout_i,
    input  logic           pq_empty_i,
    output logic           out_valid_o,
    output logic [W-1:0]   out_data_o,
    output logic           out_last_o,
    input  logic           out_ready_i,
    output logic           done_o,
    output logic [7:0]     err_cnt_o
);

    localparam int CW = $clog2(N + 1);

    state_t          state, state_next;
    logic [N*W-1:0]  keys;
    logic [CW-1:0]   push_idx;
    logic [CW-1:0]   pop_cnt;
    logic            accept;
    logic            out_hs;

    assign accept   = stim_i[N*W] && (state == IDLE);
    assign out_hs   = out_valid_o && out_ready_i;
    assign pq_din_o = keys[int'(push_idx)*W +: W];

    // NOTE: every output of this process gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_next   = state;
        stim_ready_o = 1'b0;
        pq_push_o    = 1'b0;
        pq_pop_o     = 1'b0;
        done_o       = 1'b0;
        case (state)
            IDLE: begin
                stim_ready_o = 1'b1;
                if (accept)
                    state_next = LOAD;
            end
            LOAD: begin
                pq_push_o = !pq_full_i;
                if (pq_push_o && (push_idx == CW'(N - 1)))
                    state_next = DRAIN;
            end
            DRAIN: begin
                pq_pop_o = !pq_empty_i && (pop_cnt < CW'(N)) && (!out_valid_o || out_ready_i);
                if (out_hs && out_last_o)
                    state_next = DONE;
            end
            DONE: begin
                done_o     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: the key register is reset as well, so pq_din_o reads zero out of reset
    // instead of whatever the flops powered up with.
    always_ff @(posedge system1000 or posedge system1000_rst) begin
        if (system1000_rst) begin
            state       <= IDLE;
            keys        <= '0;
            push_idx    <= '0;
            pop_cnt     <= '0;
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            out_last_o  <= 1'b0;
        end else begin
            state <= state_next;
            if (accept)
                keys <= stim_i[N*W-1:0];
            if (pq_push_o)
                push_idx <= (push_idx == CW'(N - 1)) ? '0 : push_idx + 1'b1;
            // A pop refills the output register in the same cycle it is consumed.
            if (pq_pop_o) begin
                out_data_o  <= pq_dout_i;
                out_valid_o <= 1'b1;
                out_last_o  <= (pop_cnt == CW'(N - 1));
                pop_cnt     <= pop_cnt + 1'b1;
            end else if (out_hs) begin
                out_valid_o <= 1'b0;
                out_last_o  <= 1'b0;
            end
            if (state == DONE) begin
                pop_cnt  <= '0;
                push_idx <= '0;
            end
        end
    end

    sort_order_checker #(.W(W)) u_checker (
        .clk     (system1000),
        .rst     (system1000_rst),
        .pop     (pq_pop_o),
        .first   (pop_cnt == '0),
        .clear   (done_o),
        .key     (pq_dout_i),
        .err_cnt (err_cnt_o)
    );

endmodule

// File: tb/tb_heap_sort_sequencer.sv
// Self-checking bench: table of runs against a behavioural priority-queue model,
// a scoreboard of expected popped keys, plus a hand-written mid-run reset.
module tb_heap_sort_sequencer;
    import heap_sort_sequencer_pkg::*;

    localparam int N = 10;
    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N*W:0]   stim = '0;
    logic           stim_ready;
    logic           pq_push;
    logic [W-1:0]   pq_din;
    logic           pq_full = 1'b0;
    logic           pq_pop;
    logic [W-1:0]   pq_dout = '0;
    logic           pq_empty = 1'b1;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic           out_last;
    logic           out_ready = 1'b1;
    logic           done;
    logic [7:0]     err_cnt;

    heap_sort_sequencer #(.N(N), .W(W)) dut (
        .system1000     (clk),
        .system1000_rst (rst),
        .stim_i         (stim),
        .stim_ready_o   (stim_ready),
        .pq_push_o      (pq_push),
        .pq_din_o       (pq_din),
        .pq_full_i      (pq_full),
        .pq_pop_o       (pq_pop),
        .pq_dout_i      (pq_dout),
        .pq_empty_i     (pq_empty),
        .out_valid_o    (out_valid),
        .out_data_o     (out_data),
        .out_last_o     (out_last),
        .out_ready_i    (out_ready),
        .done_o         (done),
        .err_cnt_o      (err_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- priority-queue model ----------------
    int   q[$];
    bit   faulty = 1'b0;
    int   fseq[N] = '{1, 3, 2, 5, 4, 6, 7, 8, 9, 10};
    logic push_q = 1'b0, pop_q = 1'b0;
    logic [W-1:0] din_q = '0;

    function automatic int q_min_idx();
        int mi;
        mi = 0;
        for (int i = 1; i < q.size(); i++)
            if (q[i] < q[mi]) mi = i;
        return mi;
    endfunction

    always @(posedge clk) begin
        push_q <= pq_push;
        pop_q  <= pq_pop;
        din_q  <= pq_din;
    end

    // Strobes captured at the edge are applied half a cycle later, so the head
    // seen at the next edge reflects the queue after this edge's push/pop.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
        end else begin
            if (pop_q && q.size() > 0) q.delete(q_min_idx());
            if (push_q) q.push_back(int'(din_q));
        end
        if (q.size() == 0) begin
            pq_empty = 1'b1;
            pq_dout  = '0;
        end else begin
            pq_empty = 1'b0;
            if (faulty) pq_dout = W'(fseq[N - q.size()]);
            else        pq_dout = W'(q[q_min_idx()]);
        end
    end

    // ---------------- output scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int hs_cnt = 0;

    always @(negedge clk) begin
        logic [W-1:0] e;
        if (!rst && out_valid && out_ready) begin
            hs_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL extra_key: got %0h expected no key", out_data);
            end else begin
                e = exp_q.pop_front();
                check("out_data", 32'(out_data), 32'(e));
                check("out_last", 32'(out_last), 32'(exp_q.size() == 0));
            end
        end
    end

    // ---------------- run table ----------------
    typedef struct {
        logic [N*W-1:0] keys;
        bit             faulty;
        bit             toggle;
        bit             stall;
        logic [7:0]     exp_err;
        int             exp_done;
        int             exp_fv;
    } vec_t;

    vec_t tbl[6];
    bit   pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    task automatic run_vec(input vec_t v);
        logic [W-1:0] k[N];
        logic [W-1:0] t;
        logic [W-1:0] prev_data;
        logic         prev_valid, prev_last, rdy;
        int base, done_e, fv_e;

        faulty = v.faulty;
        for (int i = 0; i < N; i++) k[i] = v.keys[i*W +: W];
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N - 1 - i; j++)
                if (k[j] > k[j+1]) begin t = k[j]; k[j] = k[j+1]; k[j+1] = t; end
        for (int i = 0; i < N; i++)
            exp_q.push_back(v.faulty ? W'(fseq[i]) : k[i]);

        base = hs_cnt;
        check("stim_ready_idle", 32'(stim_ready), 32'd1);
        stim      = {1'b1, v.keys};
        out_ready = 1'b1;
        pq_full   = 1'b0;
        @(posedge clk); #1;
        stim[N*W] = 1'b0;
        check("stim_ready_busy", 32'(stim_ready), 32'd0);

        done_e = -1; fv_e = -1;
        prev_valid = 1'b0; prev_last = 1'b0; prev_data = '0;
        for (int e = 1; e <= 200 && done_e < 0; e++) begin
            rdy       = v.toggle ? pat[e % 4] : 1'b1;
            out_ready = rdy;
            pq_full   = v.stall && e >= 5 && e <= 7;
            #1;
            if (v.stall && e >= 5 && e <= 7) begin
                check("stall_push", 32'(pq_push), 32'd0);
                check("stall_din", 32'(pq_din), 32'(v.keys[4*W +: W]));
            end
            @(posedge clk); #1;
            if (!rdy && prev_valid) begin
                check("hold_data", 32'(out_data), 32'(prev_data));
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_last", 32'(out_last), 32'(prev_last));
            end
            if (out_valid && fv_e < 0) fv_e = e;
            if (done) done_e = e;
            prev_valid = out_valid;
            prev_data  = out_data;
            prev_last  = out_last;
        end

        check("done_seen", 32'(done_e > 0), 32'd1);
        if (v.exp_done >= 0) check("done_edge", 32'(done_e), 32'(v.exp_done));
        if (v.exp_fv >= 0)   check("first_valid_edge", 32'(fv_e), 32'(v.exp_fv));
        check("err_cnt", 32'(err_cnt), 32'(v.exp_err));
        check("handshakes", 32'(hs_cnt - base), 32'(N));
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        pq_full   = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("done_one_cycle", 32'(done), 32'd0);
        check("ready_again", 32'(stim_ready), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_stim_ready"}, 32'(stim_ready), 32'd1);
        check({tag, "_push"},       32'(pq_push),    32'd0);
        check({tag, "_din"},        32'(pq_din),     32'd0);
        check({tag, "_pop"},        32'(pq_pop),     32'd0);
        check({tag, "_out_valid"},  32'(out_valid),  32'd0);
        check({tag, "_out_data"},   32'(out_data),   32'd0);
        check({tag, "_out_last"},   32'(out_last),   32'd0);
        check({tag, "_done"},       32'(done),       32'd0);
        check({tag, "_err_cnt"},    32'(err_cnt),    32'd0);
    endtask

    initial begin
        vec_t v;

        for (int i = 0; i < 6; i++) begin
            tbl[i].keys     = '0;
            tbl[i].faulty   = 1'b0;
            tbl[i].toggle   = 1'b0;
            tbl[i].stall    = 1'b0;
            tbl[i].exp_err  = 8'd0;
            tbl[i].exp_done = 2*N + 1;
            tbl[i].exp_fv   = N + 1;
        end
        for (int k = 0; k < N; k++) begin
            tbl[0].keys[k*W +: W] = W'(9 - k);
            tbl[1].keys[k*W +: W] = 16'h7FFF;
            tbl[2].keys[k*W +: W] = W'((k * 40503 + 123) & 16'hFFFF);
            tbl[3].keys[k*W +: W] = W'(100 + (k * 3) % 10);
            tbl[4].keys[k*W +: W] = W'(k);
            tbl[5].keys[k*W +: W] = W'(k);
        end
        tbl[2].toggle   = 1'b1;
        tbl[2].exp_done = -1;
        tbl[2].exp_fv   = -1;
        tbl[3].stall    = 1'b1;
        tbl[3].exp_done = 2*N + 4;
        tbl[3].exp_fv   = N + 4;
        tbl[4].faulty   = 1'b1;
        tbl[4].exp_err  = 8'd2;
        tbl[5].faulty   = 1'b1;
        tbl[5].exp_err  = 8'd4;

        #1;
        check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) run_vec(tbl[i]);

        // Mid-DRAIN reset: abort right after the 5th pop (edge N+5).
        faulty = 1'b0;
        for (int i = 0; i < N; i++) exp_q.push_back(W'(i));
        stim = {1'b1, tbl[0].keys};
        @(posedge clk); #1;
        stim[N*W] = 1'b0;
        repeat (N + 5) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        v = tbl[0];
        run_vec(v);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
